// File: rtl/elevator_call_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : elevator_call_scheduler
// Brief    : SCAN call scheduler for a 4-floor car: latches button calls and
//            presents the next target floor, with a door-dwell between stops.
//            Optional CALL_SYNC_EN adds a 2-flop synchronizer on call_btn.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_call_scheduler #(
  parameter int DWELL_CYCLES = 8,
  parameter int DWELL_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] call_btn,
  input  logic [1:0] floor_status,
  output logic [1:0] calling_status,
  output logic [3:0] pending,
  output logic       dir_up,
  output logic       busy,
  output logic       door_hold
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_DWELL  = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

  state_t             state_q, state_d;
  logic [1:0]         target_q, target_d;
  logic [3:0]         pend_q, pend_d;
  logic               dir_q, dir_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [3:0]         btn_q, btn_src, rise, set_mask, clr_mask;
  logic [1:0]         sel_tgt, btw_floor;
  logic               sel_dir, btw_hit;

`ifdef CALL_SYNC_EN
  logic [3:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= call_btn;
      sync2_q <= sync1_q;
    end
  end
  assign btn_src = sync2_q;
`else
  assign btn_src = call_btn;
`endif

  assign rise     = btn_src & ~btn_q;
  // The door is already open at the current floor, so a press there is moot.
  assign set_mask = rise & ~((state_q == ST_DWELL) ? (4'b0001 << floor_status) : 4'b0000);

  // Returns {new_dir_up, target}: current floor first, then continue the
  // scan direction, reversing only when nothing lies ahead.
  function automatic logic [2:0] sel(input logic [1:0] f, input logic up, input logic [3:0] p);
    logic [1:0] above, below, tgt;
    logic       has_above, has_below, nd;
    above = '0; below = '0; has_above = 1'b0; has_below = 1'b0;
    for (int i = 3; i >= 0; i--)
      if (p[i] && (i > int'(f))) begin above = 2'(i); has_above = 1'b1; end
    for (int i = 0; i < 4; i++)
      if (p[i] && (i < int'(f))) begin below = 2'(i); has_below = 1'b1; end
    if (p[f])    tgt = f;
    else if (up) tgt = has_above ? above : below;
    else         tgt = has_below ? below : above;
    nd = (tgt == f) ? up : (tgt > f);
    return {nd, tgt};
  endfunction

  assign {sel_dir, sel_tgt} = sel(floor_status, dir_q, pend_q);

  always_comb begin
    btw_hit   = 1'b0;
    btw_floor = target_q;
    if (target_q > floor_status) begin
      for (int i = 3; i >= 0; i--)
        if (pend_q[i] && (i > int'(floor_status)) && (i < int'(target_q))) begin
          btw_floor = 2'(i);
          btw_hit   = 1'b1;
        end
    end else begin
      for (int i = 0; i < 4; i++)
        if (pend_q[i] && (i < int'(floor_status)) && (i > int'(target_q))) begin
          btw_floor = 2'(i);
          btw_hit   = 1'b1;
        end
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    clr_mask = '0;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (|pend_q) begin
            target_d = sel_tgt;
            dir_d    = sel_dir;
            state_d  = ST_MOVING;
          end
        end
        ST_MOVING: begin
          if (floor_status == target_q) begin
            clr_mask = 4'b0001 << target_q;
            cnt_d    = DWELL_LOAD;
            state_d  = ST_DWELL;
          end else if (btw_hit) begin
            target_d = btw_floor;
            dir_d    = (btw_floor > floor_status);
          end
        end
        ST_DWELL: begin
          if (cnt_q == '0) begin
            if (|pend_q) begin
              target_d = sel_tgt;
              dir_d    = sel_dir;
              state_d  = ST_MOVING;
            end else begin
              state_d  = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q - DWELL_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Arrival clear outranks a same-cycle press of that floor.
    pend_d = (pend_q | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    // Edge history keeps tracking through reset so a press held across reset
    // is not mistaken for a new call.
    btn_q <= btn_src;
    if (reset) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      pend_q   <= '0;
      dir_q    <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      pend_q   <= pend_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
    end
  end

  assign calling_status = target_q;
  assign pending        = pend_q;
  assign dir_up         = dir_q;
  assign busy           = (state_q != ST_IDLE);
  assign door_hold      = (state_q == ST_DWELL);

endmodule
`default_nettype wire
